// File: rtl/irq_controller.sv
// Fixed-priority interrupt sequencer: synchronises edge events into pending bits and redirects the core at instruction boundaries.
// Take is combinational in the boundary cycle; pending is visible 3 edges after a raw rising edge; config reads are combinational.
module irq_controller #(
  parameter int              NSRC       = 4,
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] VEC_BASE   = 32'h0000_0100,
  parameter int              VEC_STRIDE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_src,
  input  logic            instr_boundary,
  input  logic [XLEN-1:0] core_pc,
  input  logic            mret,
  output logic            irq_take,
  output logic [XLEN-1:0] irq_vector,
  output logic [XLEN-1:0] epc,
  output logic            in_service,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_addr,
  input  logic [XLEN-1:0] cfg_wdata,
  output logic [XLEN-1:0] cfg_rdata
);

  localparam int CW = (NSRC > 1) ? $clog2(NSRC) : 1;

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] SERVICE = 1'b1;

  logic [NSRC-1:0] sync1, sync2, hist;
  logic [NSRC-1:0] pending, pending_nxt, enable, eligible, rise;
  logic [CW-1:0]   cause, sel;
  logic [0:0]      state, state_nxt;
  logic            unused_wdata;

  assign unused_wdata = ^cfg_wdata[XLEN-1:NSRC];

  assign rise     = sync2 & ~hist;
  assign eligible = pending & enable;

  // Lowest index wins, so scan from the top and let lower hits overwrite.
  always_comb begin
    sel = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) sel = CW'(i);
    end
  end

  assign in_service = (state == SERVICE);
  assign irq_take   = (state == IDLE) && instr_boundary && (|eligible);
  assign irq_vector = VEC_BASE + XLEN'(sel) * XLEN'(VEC_STRIDE);

  // A fresh edge beats a W1C of the same bit, but the bit being taken is always consumed.
  always_comb begin
    pending_nxt = pending;
    if (cfg_we && cfg_addr == 2'd1) pending_nxt = pending_nxt & ~cfg_wdata[NSRC-1:0];
    pending_nxt = pending_nxt | rise;
    if (irq_take) pending_nxt[sel] = 1'b0;
  end

  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if (irq_take) state_nxt = SERVICE;
    end else begin
      if (mret) state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1   <= '0;
      sync2   <= '0;
      hist    <= '0;
      pending <= '0;
      enable  <= '0;
      epc     <= '0;
      cause   <= '0;
      state   <= IDLE;
    end else begin
      sync1   <= irq_src;
      sync2   <= sync1;
      hist    <= sync2;
      pending <= pending_nxt;
      state   <= state_nxt;
      if (cfg_we && cfg_addr == 2'd0) enable <= cfg_wdata[NSRC-1:0];
      if (irq_take) begin
        epc   <= core_pc;
        cause <= sel;
      end
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0:    cfg_rdata[NSRC-1:0] = enable;
      2'd1:    cfg_rdata[NSRC-1:0] = pending;
      2'd2:    cfg_rdata = epc;
      default: cfg_rdata[CW-1:0] = cause;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: reset, capture timing, priority, enable/W1C, boundary gating and mid-service reset.
module tb_irq_controller;

  logic        clk;
  logic        rst;
  logic [3:0]  irq_src;
  logic        instr_boundary;
  logic [31:0] core_pc;
  logic        mret;
  logic        irq_take;
  logic [31:0] irq_vector;
  logic [31:0] epc;
  logic        in_service;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;

  int total = 0;
  int bad   = 0;

  irq_controller dut (
    .clk            (clk),
    .rst            (rst),
    .irq_src        (irq_src),
    .instr_boundary (instr_boundary),
    .core_pc        (core_pc),
    .mret           (mret),
    .irq_take       (irq_take),
    .irq_vector     (irq_vector),
    .epc            (epc),
    .in_service     (in_service),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_wdata      (cfg_wdata),
    .cfg_rdata      (cfg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    cfg_addr = addr;
    #1;
    chk(tag, cfg_rdata, exp);
  endtask

  task automatic cfg_wr(input logic [1:0] addr, input logic [31:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    step();
    cfg_we    = 1'b0;
    cfg_wdata = '0;
  endtask

  task automatic pulse(input logic [3:0] mask);
    irq_src = mask;
    step();
    irq_src = '0;
  endtask

  initial begin
    rst = 1'b0; irq_src = 4'hF; instr_boundary = 1'b0; core_pc = '0;
    mret = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;

    // 1: reset with all lines high
    step(); step();
    chk("rst_take", {31'd0, irq_take}, 32'd0);
    chk("rst_insvc", {31'd0, in_service}, 32'd0);
    chk("rst_epc", epc, 32'd0);
    rd_chk("rst_rd0", 2'd0, 32'd0);
    rd_chk("rst_rd1", 2'd1, 32'd0);
    rd_chk("rst_rd2", 2'd2, 32'd0);
    rd_chk("rst_rd3", 2'd3, 32'd0);
    rst = 1'b1; irq_src = 4'h0;
    step(); step(); step();
    rd_chk("post_rst_pend", 2'd1, 32'd0);

    // 2: single source, exact latency
    cfg_wr(2'd0, 32'h1);
    rd_chk("en_rd", 2'd0, 32'h1);
    core_pc = 32'h40; instr_boundary = 1'b1;
    pulse(4'h1);
    chk("t2_c1_take", {31'd0, irq_take}, 32'd0);
    step();
    chk("t2_c2_take", {31'd0, irq_take}, 32'd0);
    step();
    chk("t2_c3_take", {31'd0, irq_take}, 32'd1);
    chk("t2_vec", irq_vector, 32'h100);
    step();
    chk("t2_insvc", {31'd0, in_service}, 32'd1);
    chk("t2_take_once", {31'd0, irq_take}, 32'd0);
    rd_chk("t2_epc", 2'd2, 32'h40);
    rd_chk("t2_cause", 2'd3, 32'd0);
    rd_chk("t2_pend", 2'd1, 32'd0);
    mret = 1'b1;
    #1;
    chk("t2_insvc_mret", {31'd0, in_service}, 32'd1);
    step();
    mret = 1'b0;
    chk("t2_insvc_off", {31'd0, in_service}, 32'd0);
    chk("t2_epc_hold", epc, 32'h40);

    // 3: priority between simultaneous sources
    cfg_wr(2'd0, 32'hF);
    pulse(4'hA);
    step(); step();
    chk("t3_take", {31'd0, irq_take}, 32'd1);
    chk("t3_vec", irq_vector, 32'h104);
    step();
    core_pc = 32'h80;
    rd_chk("t3_pend", 2'd1, 32'h8);
    rd_chk("t3_cause", 2'd3, 32'd1);
    chk("t3_nonest", {31'd0, irq_take}, 32'd0);
    step();
    chk("t3_nonest2", {31'd0, irq_take}, 32'd0);
    mret = 1'b1;
    #1;
    chk("t3_mret_cycle_take", {31'd0, irq_take}, 32'd0);
    step();
    mret = 1'b0;
    chk("t3_insvc_off", {31'd0, in_service}, 32'd0);
    chk("t3_take2", {31'd0, irq_take}, 32'd1);
    chk("t3_vec2", irq_vector, 32'h10C);
    step();
    rd_chk("t3_cause2", 2'd3, 32'd3);
    rd_chk("t3_epc2", 2'd2, 32'h80);
    mret = 1'b1; step(); mret = 1'b0;

    // 4: enable gating and W1C
    cfg_wr(2'd0, 32'h0);
    pulse(4'h4);
    step(); step();
    rd_chk("t4_pend", 2'd1, 32'h4);
    for (int i = 0; i < 10; i++) begin
      chk("t4_masked_take", {31'd0, irq_take}, 32'd0);
      step();
    end
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'h4;
    #1;
    chk("t4_wr_cycle_take", {31'd0, irq_take}, 32'd0);
    step();
    cfg_we = 1'b0; cfg_wdata = '0;
    chk("t4_take", {31'd0, irq_take}, 32'd1);
    chk("t4_vec", irq_vector, 32'h108);
    step();
    mret = 1'b1; step(); mret = 1'b0;
    cfg_wr(2'd0, 32'h0);
    pulse(4'h4);
    step(); step();
    rd_chk("t4_pend2", 2'd1, 32'h4);
    pulse(4'h4);
    step();
    cfg_wr(2'd1, 32'h4);
    rd_chk("t4_edge_beats_w1c", 2'd1, 32'h4);
    cfg_wr(2'd1, 32'h4);
    rd_chk("t4_w1c", 2'd1, 32'h0);
    cfg_wr(2'd2, 32'hDEAD);
    rd_chk("t4_epc_ro", 2'd2, 32'h80);
    cfg_wr(2'd0, 32'h4);
    chk("t4_no_take", {31'd0, irq_take}, 32'd0);
    step();
    chk("t4_no_take2", {31'd0, irq_take}, 32'd0);

    // 5: boundary gating, no nesting, held line
    cfg_wr(2'd0, 32'h1);
    instr_boundary = 1'b0;
    pulse(4'h1);
    step(); step();
    for (int i = 0; i < 5; i++) begin
      chk("t5_noboundary", {31'd0, irq_take}, 32'd0);
      step();
    end
    core_pc = 32'h200; instr_boundary = 1'b1;
    #1;
    chk("t5_take", {31'd0, irq_take}, 32'd1);
    chk("t5_vec", irq_vector, 32'h100);
    step();
    rd_chk("t5_epc", 2'd2, 32'h200);
    pulse(4'h1);
    step(); step();
    rd_chk("t5_pend_insvc", 2'd1, 32'h1);
    chk("t5_insvc_notake", {31'd0, irq_take}, 32'd0);
    mret = 1'b1; step(); mret = 1'b0;
    chk("t5_take_after_mret", {31'd0, irq_take}, 32'd1);
    step();
    rd_chk("t5_pend_cleared", 2'd1, 32'h0);
    irq_src = 4'h1;
    step(); step(); step(); step();
    rd_chk("t5_held_pend", 2'd1, 32'h1);
    cfg_wr(2'd1, 32'h1);
    step(); step(); step(); step(); step();
    rd_chk("t5_held_once", 2'd1, 32'h0);
    irq_src = 4'h0;
    step(); step();
    pulse(4'h1);
    step(); step();
    rd_chk("t5_rearm", 2'd1, 32'h1);
    cfg_wr(2'd1, 32'h1);

    // 6: reset during service
    pulse(4'h2);
    step(); step();
    rd_chk("t6_pend", 2'd1, 32'h2);
    chk("t6_insvc", {31'd0, in_service}, 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t6_insvc_off", {31'd0, in_service}, 32'd0);
    rd_chk("t6_pend_zero", 2'd1, 32'h0);
    rd_chk("t6_epc_zero", 2'd2, 32'h0);
    rd_chk("t6_en_zero", 2'd0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("t6_no_take", {31'd0, irq_take}, 32'd0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
